// File: rtl/refund_dispenser.sv
// Coin refund dispenser: pays a cents amount out of three hoppers, largest
// eligible coin first, with one shared eject acknowledge and an ack timeout.
module refund_dispenser #(
  parameter int unsigned HI_VAL      = 1000,
  parameter int unsigned LO_VAL      = 100,
  parameter int unsigned HALF_VAL    = 50,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_refund_req,
  input  logic [31:0] i_refund_amt,
  input  logic        i_eject_ack,
  input  logic        i_empty_hi,
  input  logic        i_empty_lo,
  input  logic        i_empty_half,
  output logic        o_eject_hi,
  output logic        o_eject_lo,
  output logic        o_eject_half,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_remaining,
  output logic [7:0]  o_coin_count
);

  localparam int unsigned AMT_W  = 32;
  localparam int unsigned CNT_W  = 8;
  // Wait counter only needs to hold 0 .. ACK_TIMEOUT-1 (ACK_TIMEOUT >= 1 assumed)
  localparam int unsigned WAIT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_EJECT   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // One-hot coin codes, bit order {hi, lo, half} matches the eject lines
  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_HI   = 3'b100;
  localparam logic [2:0] C_LO   = 3'b010;
  localparam logic [2:0] C_HALF = 3'b001;

  logic [2:0]        r_state;
  logic [2:0]        r_coin;
  logic [2:0]        r_eject;
  logic [WAIT_W-1:0] r_wait;
  logic [AMT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_coin_count;
  logic              r_fault;
  logic              r_busy;
  logic              r_done;

  logic [2:0]        w_state_nxt;
  logic [2:0]        w_coin_nxt;
  logic [2:0]        w_eject_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [AMT_W-1:0]  w_remaining_nxt;
  logic [CNT_W-1:0]  w_coin_count_nxt;
  logic              w_fault_nxt;
  logic [AMT_W-1:0]  w_coin_val;
  logic              w_hi_ok;
  logic              w_lo_ok;
  logic              w_half_ok;

  // A coin is eligible only if its hopper has coins and it cannot underflow
  assign w_hi_ok   = !i_empty_hi   && (r_remaining >= AMT_W'(HI_VAL));
  assign w_lo_ok   = !i_empty_lo   && (r_remaining >= AMT_W'(LO_VAL));
  assign w_half_ok = !i_empty_half && (r_remaining >= AMT_W'(HALF_VAL));

  // Value of the coin latched for the current eject
  always_comb begin
    w_coin_val = '0;
    case (r_coin)
      C_HI:    w_coin_val = AMT_W'(HI_VAL);
      C_LO:    w_coin_val = AMT_W'(LO_VAL);
      C_HALF:  w_coin_val = AMT_W'(HALF_VAL);
      default: w_coin_val = '0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_coin_nxt       = r_coin;
    w_eject_nxt      = r_eject;
    w_wait_nxt       = r_wait;
    w_remaining_nxt  = r_remaining;
    w_coin_count_nxt = r_coin_count;
    w_fault_nxt      = r_fault;
    case (r_state)
      S_IDLE: begin
        if (i_refund_req) begin
          w_remaining_nxt  = i_refund_amt;
          w_coin_count_nxt = '0;
          w_fault_nxt      = 1'b0;
          w_state_nxt      = (i_refund_amt == '0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        w_wait_nxt = '0;
        if (w_hi_ok) begin
          w_coin_nxt  = C_HI;
          w_state_nxt = S_EJECT;
        end else if (w_lo_ok) begin
          w_coin_nxt  = C_LO;
          w_state_nxt = S_EJECT;
        end else if (w_half_ok) begin
          w_coin_nxt  = C_HALF;
          w_state_nxt = S_EJECT;
        end else begin
          w_fault_nxt = (r_remaining != '0);
          w_state_nxt = S_DONE;
        end
      end
      S_EJECT: begin
        // First EJECT cycle raises the line; ack is honoured only while it is up
        if (r_eject == C_NONE) begin
          w_eject_nxt = r_coin;
        end else if (i_eject_ack) begin
          w_eject_nxt     = C_NONE;
          w_remaining_nxt = r_remaining - w_coin_val;
          if (r_coin_count != CNT_MAX) begin
            w_coin_count_nxt = r_coin_count + CNT_W'(1);
          end
          w_state_nxt = S_RELEASE;
        end else if (r_wait == WAIT_LAST) begin
          w_eject_nxt = C_NONE;
          w_fault_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      S_RELEASE: begin
        if (!i_eject_ack) begin
          w_state_nxt = S_SELECT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_eject_nxt = C_NONE;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_coin       <= C_NONE;
      r_eject      <= C_NONE;
      r_wait       <= '0;
      r_remaining  <= '0;
      r_coin_count <= '0;
      r_fault      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_coin       <= w_coin_nxt;
      r_eject      <= w_eject_nxt;
      r_wait       <= w_wait_nxt;
      r_remaining  <= w_remaining_nxt;
      r_coin_count <= w_coin_count_nxt;
      r_fault      <= w_fault_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  assign o_eject_hi   = r_eject[2];
  assign o_eject_lo   = r_eject[1];
  assign o_eject_half = r_eject[0];
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fault      = r_fault;
  assign o_remaining  = r_remaining;
  assign o_coin_count = r_coin_count;

endmodule

// File: tb/tb_refund_dispenser.sv
// Self-checking bench for refund_dispenser: hopper responder, output monitor
// and a greedy-change reference model.
module tb_refund_dispenser;

  localparam int unsigned HI   = 1000;
  localparam int unsigned LO   = 100;
  localparam int unsigned HALF = 50;
  localparam int unsigned TO   = 255;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_refund_req;
  logic [31:0] i_refund_amt;
  logic        i_eject_ack;
  logic        i_empty_hi, i_empty_lo, i_empty_half;
  logic        o_eject_hi, o_eject_lo, o_eject_half;
  logic        o_busy, o_done, o_fault;
  logic [31:0] o_remaining;
  logic [7:0]  o_coin_count;

  int checks = 0;
  int errors = 0;

  bit ack_en    = 1'b1;
  int ack_delay = 0;

  int         done_cnt;
  int         ej_cycles;
  int         multi_err;
  logic [2:0] obs_seq[$];

  int unsigned exp_rem;
  int unsigned exp_cnt;
  bit          exp_fault;
  logic [2:0]  exp_seq[$];

  always #5 clk = ~clk;

  refund_dispenser #(.HI_VAL(HI), .LO_VAL(LO), .HALF_VAL(HALF), .ACK_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_refund_req(i_refund_req), .i_refund_amt(i_refund_amt),
    .i_eject_ack(i_eject_ack), .i_empty_hi(i_empty_hi), .i_empty_lo(i_empty_lo),
    .i_empty_half(i_empty_half), .o_eject_hi(o_eject_hi), .o_eject_lo(o_eject_lo),
    .o_eject_half(o_eject_half), .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault),
    .o_remaining(o_remaining), .o_coin_count(o_coin_count)
  );

  // Hopper: ack ack_delay cycles after an eject appears, drop ack once eject drops
  initial begin
    int wc;
    wc = 0;
    i_eject_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!i_eject_ack) begin
        if (ack_en && (o_eject_hi || o_eject_lo || o_eject_half)) begin
          if (wc >= ack_delay) begin
            i_eject_ack = 1'b1;
            wc = 0;
          end else begin
            wc++;
          end
        end else begin
          wc = 0;
        end
      end else if (!(o_eject_hi || o_eject_lo || o_eject_half)) begin
        i_eject_ack = 1'b0;
      end
    end
  end

  // Monitor: eject order, eject-high cycles, one-hot violations, done pulses
  initial begin
    logic [2:0] ej, prev_ej;
    prev_ej = 3'b000;
    forever begin
      @(negedge clk);
      ej = {o_eject_hi, o_eject_lo, o_eject_half};
      if ($countones(ej) > 1) multi_err++;
      if ((ej & ~prev_ej) != 3'b000) obs_seq.push_back(ej);
      if (ej != 3'b000) ej_cycles++;
      if (o_done) done_cnt++;
      prev_ej = ej;
    end
  end

  task automatic clear_mon();
    done_cnt  = 0;
    ej_cycles = 0;
    multi_err = 0;
    obs_seq.delete();
  endtask

  // Reference: greedy change-making over the non-empty hoppers
  task automatic model(input int unsigned amt, input bit eh, input bit el, input bit ehf,
                       input bit ack_ok);
    int unsigned rem, v;
    logic [2:0]  code;
    rem = amt; exp_cnt = 0; exp_fault = 1'b0; exp_seq.delete();
    forever begin
      if (!eh && rem >= HI)        begin v = HI;   code = 3'b100; end
      else if (!el && rem >= LO)   begin v = LO;   code = 3'b010; end
      else if (!ehf && rem >= HALF) begin v = HALF; code = 3'b001; end
      else begin
        if (rem != 0) exp_fault = 1'b1;
        break;
      end
      exp_seq.push_back(code);
      if (!ack_ok) begin exp_fault = 1'b1; break; end
      rem = rem - v;
      if (exp_cnt < 255) exp_cnt++;
    end
    exp_rem = rem;
  endtask

  // Issue one request and wait (bounded) for done; poke toggles req while busy
  task automatic do_refund(input logic [31:0] amt, input bit poke, output bit ok,
                           output int lat);
    i_refund_amt = amt;
    i_refund_req = 1'b1;
    @(posedge clk); #1;
    i_refund_req = 1'b0;
    ok = 1'b0; lat = 0;
    for (int c = 0; c < 6000; c++) begin
      if (o_done) begin ok = 1'b1; break; end
      if (poke) begin
        i_refund_req = ~i_refund_req;
        i_refund_amt = 32'd50;
      end
      @(posedge clk); #1;
      lat++;
    end
    i_refund_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    #2;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if ({o_eject_hi, o_eject_lo, o_eject_half} !== 3'b000) begin errors++; $display("FAIL reset_eject got %b want 000", {o_eject_hi, o_eject_lo, o_eject_half}); end
    checks++; if (o_remaining !== 32'd0 || o_coin_count !== 8'd0 || o_fault !== 1'b0) begin errors++; $display("FAIL reset_regs got rem=%0d cnt=%0d fault=%b want 0/0/0", o_remaining, o_coin_count, o_fault); end
    @(negedge clk); i_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    ok = 1'b0;
    clear_mon(); ack_delay = 0;
    model(1150, 0, 0, 0, 1);
    i_refund_amt = 32'd1150; i_refund_req = 1'b1;
    @(posedge clk); #1; i_refund_req = 1'b0;
    checks++; if (o_busy !== 1'b1 || o_eject_hi !== 1'b0) begin errors++; $display("FAIL basic_lat_k got busy=%b hi=%b want 1/0", o_busy, o_eject_hi); end
    @(posedge clk); #1;
    checks++; if (o_eject_hi !== 1'b0) begin errors++; $display("FAIL basic_lat_k1 got hi=%b want 0", o_eject_hi); end
    @(posedge clk); #1;
    checks++; if (o_eject_hi !== 1'b1) begin errors++; $display("FAIL basic_lat_k2 got hi=%b want 1", o_eject_hi); end
    for (int c = 0; c < 200; c++) begin
      if (o_done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done_wait got %b want 1", ok); end
    @(posedge clk); #1;
    checks++; if (o_remaining !== exp_rem || o_coin_count !== 8'(exp_cnt) || o_fault !== exp_fault) begin errors++; $display("FAIL basic_result got rem=%0d cnt=%0d fault=%b want %0d/%0d/%b", o_remaining, o_coin_count, o_fault, exp_rem, exp_cnt, exp_fault); end
    checks++; if (obs_seq.size() != 3 || obs_seq[0] !== exp_seq[0] || obs_seq[1] !== exp_seq[1] || obs_seq[2] !== exp_seq[2]) begin errors++; $display("FAIL basic_order got %0d ejects want 100,010,001", obs_seq.size()); end
    checks++; if (done_cnt !== 1 || o_busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got done=%0d busy=%b want 1/0", done_cnt, o_busy); end
  endtask

  task automatic test_empty_hi();
    bit ok; int lat; int bad;
    clear_mon(); ack_delay = 1; i_empty_hi = 1'b1;
    model(1000, 1, 0, 0, 1);
    do_refund(32'd1000, 1'b0, ok, lat);
    bad = 0;
    foreach (obs_seq[i]) if (obs_seq[i] !== 3'b010) bad++;
    checks++; if (ok !== 1'b1 || o_coin_count !== 8'(exp_cnt) || o_remaining !== exp_rem || o_fault !== exp_fault) begin errors++; $display("FAIL empty_hi_result got ok=%b cnt=%0d rem=%0d fault=%b want 1/%0d/%0d/%b", ok, o_coin_count, o_remaining, o_fault, exp_cnt, exp_rem, exp_fault); end
    checks++; if (obs_seq.size() != 10 || bad != 0) begin errors++; $display("FAIL empty_hi_ejects got %0d (non-lo %0d) want 10 lo", obs_seq.size(), bad); end
    i_empty_hi = 1'b0;
  endtask

  task automatic test_unrepresentable();
    bit ok; int lat;
    clear_mon(); ack_delay = 0;
    model(130, 0, 0, 0, 1);
    do_refund(32'd130, 1'b0, ok, lat);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_fault !== 1'b1 || o_remaining !== exp_rem || o_coin_count !== 8'(exp_cnt)) begin errors++; $display("FAIL residual got fault=%b rem=%0d cnt=%0d want 1/%0d/%0d", o_fault, o_remaining, o_coin_count, exp_rem, exp_cnt); end
    checks++; if (ok !== 1'b1 || done_cnt !== 1) begin errors++; $display("FAIL residual_done got ok=%b done=%0d want 1/1", ok, done_cnt); end
  endtask

  task automatic test_timeout();
    bit ok; int lat;
    clear_mon(); ack_en = 1'b0;
    model(500, 0, 0, 0, 0);
    do_refund(32'd500, 1'b0, ok, lat);
    checks++; if (ej_cycles !== int'(TO) || obs_seq.size() != 1 || obs_seq[0] !== 3'b010) begin errors++; $display("FAIL timeout_eject got %0d cycles %0d ejects want %0d lo", ej_cycles, obs_seq.size(), TO); end
    checks++; if (o_fault !== exp_fault || o_remaining !== exp_rem || o_coin_count !== 8'(exp_cnt) || done_cnt !== 1) begin errors++; $display("FAIL timeout_result got fault=%b rem=%0d cnt=%0d done=%0d want %b/%0d/%0d/1", o_fault, o_remaining, o_coin_count, done_cnt, exp_fault, exp_rem, exp_cnt); end
    ack_en = 1'b1;
  endtask

  task automatic test_zero_and_busy();
    bit ok; int lat;
    clear_mon();
    do_refund(32'd0, 1'b0, ok, lat);
    checks++; if (ok !== 1'b1 || lat !== 0 || ej_cycles !== 0 || o_fault !== 1'b0) begin errors++; $display("FAIL zero_amt got ok=%b lat=%0d ej=%0d fault=%b want 1/0/0/0", ok, lat, ej_cycles, o_fault); end
    clear_mon(); ack_delay = 2;
    model(1150, 0, 0, 0, 1);
    do_refund(32'd1150, 1'b1, ok, lat);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_remaining !== exp_rem || o_coin_count !== 8'(exp_cnt) || o_fault !== exp_fault || done_cnt !== 1 || o_busy !== 1'b0) begin errors++; $display("FAIL busy_ignore got rem=%0d cnt=%0d fault=%b done=%0d busy=%b want %0d/%0d/%b/1/0", o_remaining, o_coin_count, o_fault, done_cnt, o_busy, exp_rem, exp_cnt, exp_fault); end
  endtask

  task automatic test_flag_change();
    bit ok;
    ok = 1'b0;
    clear_mon(); ack_delay = 2;
    i_refund_amt = 32'd1000; i_refund_req = 1'b1;
    @(posedge clk); #1; i_refund_req = 1'b0;
    for (int c = 0; c < 20 && !o_eject_hi; c++) begin @(posedge clk); #1; end
    i_empty_hi = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (o_done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++; if (ok !== 1'b1 || o_coin_count !== 8'd1 || o_remaining !== 32'd0 || o_fault !== 1'b0 || obs_seq.size() != 1) begin errors++; $display("FAIL flag_change got ok=%b cnt=%0d rem=%0d fault=%b ejects=%0d want 1/1/0/0/1", ok, o_coin_count, o_remaining, o_fault, obs_seq.size()); end
    i_empty_hi = 1'b0;
  endtask

  task automatic test_saturate();
    bit ok; int lat;
    clear_mon(); ack_delay = 0;
    i_empty_hi = 1'b1; i_empty_lo = 1'b1;
    model(15000, 1, 1, 0, 1);
    do_refund(32'd15000, 1'b0, ok, lat);
    checks++; if (ok !== 1'b1 || o_coin_count !== 8'(exp_cnt) || o_remaining !== exp_rem || obs_seq.size() != 300) begin errors++; $display("FAIL saturate got ok=%b cnt=%0d rem=%0d ejects=%0d want 1/%0d/%0d/300", ok, o_coin_count, o_remaining, obs_seq.size(), exp_cnt, exp_rem); end
    i_empty_hi = 1'b0; i_empty_lo = 1'b0;
  endtask

  task automatic test_random();
    bit ok; int lat; int bad;
    int unsigned amt;
    bit eh, el, ehf;
    for (int n = 0; n < 10; n++) begin
      amt = $urandom_range(0, 2500);
      eh = ($urandom_range(0, 3) == 0); el = ($urandom_range(0, 3) == 0);
      ehf = ($urandom_range(0, 3) == 0);
      ack_delay = int'($urandom_range(0, 3));
      i_empty_hi = eh; i_empty_lo = el; i_empty_half = ehf;
      clear_mon();
      model(amt, eh, el, ehf, 1);
      do_refund(amt, 1'b0, ok, lat);
      bad = 0;
      if (obs_seq.size() != exp_seq.size()) bad = 1;
      else foreach (exp_seq[i]) if (obs_seq[i] !== exp_seq[i]) bad++;
      checks++; if (ok !== 1'b1 || o_remaining !== exp_rem || o_coin_count !== 8'(exp_cnt) || o_fault !== exp_fault) begin errors++; $display("FAIL rand_result amt=%0d flags=%b%b%b got rem=%0d cnt=%0d fault=%b want %0d/%0d/%b", amt, eh, el, ehf, o_remaining, o_coin_count, o_fault, exp_rem, exp_cnt, exp_fault); end
      checks++; if (bad != 0 || multi_err != 0 || done_cnt != 1) begin errors++; $display("FAIL rand_ejects amt=%0d got order_err=%0d multi=%0d done=%0d want 0/0/1", amt, bad, multi_err, done_cnt); end
    end
    i_empty_hi = 1'b0; i_empty_lo = 1'b0; i_empty_half = 1'b0;
  endtask

  task automatic test_reset_mid_eject();
    bit ok; int lat;
    ack_en = 1'b0;
    i_refund_amt = 32'd1150; i_refund_req = 1'b1;
    @(posedge clk); #1; i_refund_req = 1'b0;
    for (int c = 0; c < 20 && !o_eject_hi; c++) begin @(posedge clk); #1; end
    checks++; if (o_eject_hi !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got hi=%b want 1", o_eject_hi); end
    #2; i_rst = 1'b0;
    #1;
    checks++; if ({o_eject_hi, o_eject_lo, o_eject_half, o_busy, o_done, o_fault} !== 6'b0 || o_remaining !== 32'd0 || o_coin_count !== 8'd0) begin errors++; $display("FAIL rst_mid_async got ej=%b busy=%b rem=%0d cnt=%0d want all 0", {o_eject_hi, o_eject_lo, o_eject_half}, o_busy, o_remaining, o_coin_count); end
    @(negedge clk); i_rst = 1'b1; ack_en = 1'b1;
    @(posedge clk); #1;
    clear_mon(); ack_delay = 0;
    model(130, 0, 0, 0, 1);
    do_refund(32'd130, 1'b0, ok, lat);
    checks++; if (ok !== 1'b1 || o_remaining !== exp_rem || o_coin_count !== 8'(exp_cnt) || o_fault !== exp_fault) begin errors++; $display("FAIL rst_mid_after got ok=%b rem=%0d cnt=%0d fault=%b want 1/%0d/%0d/%b", ok, o_remaining, o_coin_count, o_fault, exp_rem, exp_cnt, exp_fault); end
  endtask

  initial begin
    i_refund_req = 1'b0; i_refund_amt = 32'd0;
    i_empty_hi = 1'b0; i_empty_lo = 1'b0; i_empty_half = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_empty_hi();
    test_unrepresentable();
    test_timeout();
    test_zero_and_busy();
    test_flag_change();
    test_saturate();
    test_random();
    test_reset_mid_eject();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/refund_dispenser.md
REFUND_DISPENSER -- requirements
Module: refund_dispenser

Interface
REQ-001 Parameter HI_VAL, default 1000, value of the high-denomination coin in cents (CNY 10).
REQ-002 Parameter LO_VAL, default 100, value of the low-denomination coin in cents (CNY 1).
REQ-003 Parameter HALF_VAL, default 50, value of the half coin in cents (CNY 0.5).
REQ-004 Parameter ACK_TIMEOUT, default 255, maximum number of cycles to wait for eject_ack.
REQ-005 clk  input  1  single system clock; all state changes on posedge clk.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 refund_req  input  1  start request; sampled only in IDLE.
REQ-008 refund_amt  input  32  amount to return in cents; captured when refund_req is accepted.
REQ-009 eject_ack  input  1  hopper acknowledge, shared by all three hoppers.
REQ-010 empty_hi / empty_lo / empty_half  input  1 each  hopper-empty flags.
REQ-011 eject_hi / eject_lo / eject_half  output  1 each  coin-eject requests; at most one is high at any time.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 fault  output  1  the refund could not be fully paid.
REQ-015 remaining  output  32  cents still owed.
REQ-016 coin_count  output  8  coins dispensed in the current refund.

Function
REQ-017 The FSM SHALL have the states IDLE, SELECT, EJECT, RELEASE and DONE; all outputs SHALL be registered (Moore).
REQ-018 IDLE: when refund_req=1, the block SHALL load remaining<=refund_amt, coin_count<=0 and fault<=0, then go to DONE if refund_amt==0, otherwise to SELECT.
REQ-019 SELECT: the block SHALL choose the largest denomination with value<=remaining and its empty flag low, and go to EJECT with that coin latched.
REQ-020 SELECT, no eligible coin: if remaining==0 go to DONE; else set fault<=1 and go to DONE, leaving remaining unchanged.
REQ-021 EJECT: the latched eject line SHALL be held high until eject_ack=1 is sampled.
REQ-022 On the eject_ack edge the block SHALL deassert eject, set remaining<=remaining-value and increment coin_count (saturating at 255), then go to RELEASE.
REQ-023 EJECT timeout: a wait counter is cleared on entry to EJECT; if it reaches ACK_TIMEOUT without an ack, deassert eject, set fault<=1, go to DONE; remaining is not decremented.
REQ-024 RELEASE: the block SHALL wait for eject_ack=0, then go to SELECT; no eject is asserted in RELEASE.
REQ-025 DONE: done=1 for exactly one cycle, then go to IDLE; fault and remaining SHALL hold their values until the next accepted request.
REQ-026 Latency: refund_req sampled at edge k SHALL give an eject line visible after edge k+2 (SELECT at k+1).
REQ-027 refund_req SHALL be ignored while busy=1; no queuing.
REQ-028 An empty flag changing during EJECT SHALL NOT abort the pending eject; flags are evaluated only in SELECT.
REQ-029 Subtraction SHALL never underflow: a coin is selected only if value<=remaining.
REQ-030 An amount not representable in the available denominations (e.g. 30 cents) SHALL end with fault=1 and the residual left in remaining.

Reset
REQ-031 rst=0 SHALL immediately, independent of clk, force state=IDLE, all eject lines=0, busy=0, done=0, fault=0, remaining=0, coin_count=0 and the wait counter=0.
REQ-032 Reset asserted mid-eject SHALL abandon the refund; no coin is counted for an unacknowledged eject.

Verification
REQ-033 refund_amt=1150, all hoppers full, ack 1 cycle after eject -> eject_hi, eject_lo, eject_half in order; coin_count=3, remaining=0, fault=0, one done pulse.
REQ-034 refund_amt=1000, empty_hi=1 -> ten eject_lo handshakes; coin_count=10, remaining=0, fault=0.
REQ-035 refund_amt=130 -> one eject_lo, then fault=1, remaining=30, coin_count=1.
REQ-036 refund_amt=500, eject_ack tied 0 -> eject_lo high for 255 cycles, then fault=1, remaining=500, coin_count=0, done pulse.
REQ-037 refund_amt=0 -> done one cycle after acceptance, no eject, fault=0; refund_req pulses while busy are ignored.
REQ-038 rst=0 while eject_hi is high -> all outputs zero without waiting for a clock edge; after release, the block accepts a new request.
